debug_capture: RTL

DEBUG_CAPTURE -- requirements
Module: debug_capture

---
 rtl/debug_capture_if.sv | 20 ++
 rtl/debug_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_capture_if.sv
// -----------------------------------------------------------------------------
// debug_capture_if
//   Streaming beat bundle (valid, data, sop, eop, empty) shared by the monitored
//   input and the pass-through output of debug_capture.
//   Parameter DW : data word width in bits.
//   modport master : drives the stream.
//   modport slave  : observes the stream.
// -----------------------------------------------------------------------------
interface debug_capture_if #(
    parameter int DW = 32
);
    logic          valid;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [1:0]    empty;

    modport master (output valid, data, sop, eop, empty);
    modport slave  (input  valid, data, sop, eop, empty);
endinterface

// File: rtl/debug_capture.sv
// -----------------------------------------------------------------------------
// debug_capture
//   Stream logic-analyser: watches a streaming bus, arms on a button, triggers
//   on a beat count / eop / sop, captures up to DEPTH beats, and shows one
//   captured entry at a time on LEDs and 7-segment digits.
//
//   Ports:
//     sys_clk   : single clock, rising edge.
//     reset     : asynchronous active-high reset.
//     in        : monitored stream (slave modport).
//     out       : zero-latency copy of in (master modport).
//     SW[17:16] : trigger mode (0 count, 1 count within packet, 2 eop, 3 sop).
//     SW[15:0]  : trigger beat index for modes 0/1.
//     KEY[3:0]  : active-low buttons; [0] arm, [1] clear, [2] step, [3] unused.
//     LEDG[7:0] : [0] armed, [1] capturing, [2] done, [3] sop, [4] eop,
//                 [6:5] empty of displayed entry, [7] counter saturated.
//     hex_disp  : active-low 7-seg digits, digit i = nibble i of displayed word;
//                 blank (7'h7F) when the displayed entry is invalid.
// -----------------------------------------------------------------------------
module debug_capture #(
    parameter int DEPTH    = 4,
    parameter bit EOP_STOP = 1'b1,
    parameter int BPW      = 4
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    debug_capture_if.slave         in,
    debug_capture_if.master        out,
    input  logic [17:0]            SW,
    input  logic [3:0]             KEY,
    output logic [7:0]             LEDG,
    output logic [2*BPW-1:0][6:0]  hex_disp
);

    localparam int                DW    = 8 * BPW;
    localparam int                AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]     LAST  = AW'(DEPTH - 1);
    localparam int unsigned       NDIG  = 2 * BPW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        key_q, key_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              sat_q, sat_d;

    // Entry payload {empty, eop, sop, data}; no reset, validity lives in vld_q.
    logic [DW+3:0]     mem_q [DEPTH];

    logic              we;
    logic [AW-1:0]     waddr;
    logic [3:0]        key_evt;
    logic [1:0]        mode;
    logic [15:0]       eff_cnt;
    logic              trig_cond;
    logic              unused_key3;
    logic [DW+3:0]     rd_word;
    logic              rd_vld;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Stream pass-through, purely combinational.
    always_comb begin
        out.valid = in.valid;
        out.data  = in.data;
        out.sop   = in.sop;
        out.eop   = in.eop;
        out.empty = in.empty;
    end

    // State register.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            key_q    <= 4'hF;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem_q[waddr] <= {in.empty, in.eop, in.sop, in.data};
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d  = state_q;
        key_d    = KEY;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        we       = 1'b0;
        waddr    = wr_ptr_q;

        // Falling edge of an active-low button = one press event.
        key_evt  = key_q & ~KEY;
        mode     = SW[17:16];
        // In packet-count mode the sop beat itself is index 0.
        eff_cnt  = (mode == 2'd1 && in.sop) ? '0 : cnt_q;

        case (mode)
            2'd0, 2'd1: trig_cond = (eff_cnt == SW[15:0]);
            2'd2:       trig_cond = in.eop;
            default:    trig_cond = in.sop;
        endcase

        // Clear wins over arm; both restart the capture from scratch.
        if (key_evt[1] || key_evt[0]) begin
            state_d  = key_evt[1] ? S_IDLE : S_ARMED;
            vld_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (in.valid) begin
                        if (mode == 2'd1 && in.sop) begin
                            cnt_d = 16'd1;
                        end else if (cnt_q != '1) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        sat_d = sat_q | (cnt_d == '1);
                        if (trig_cond) begin
                            we       = 1'b1;
                            waddr    = '0;
                            vld_d[0] = 1'b1;
                            wr_ptr_d = ptr_inc('0);
                            state_d  = ((DEPTH == 1) || (EOP_STOP && in.eop)) ? S_DONE : S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (in.valid) begin
                        we              = 1'b1;
                        vld_d[wr_ptr_q] = 1'b1;
                        wr_ptr_d        = ptr_inc(wr_ptr_q);
                        if ((wr_ptr_q == LAST) || (EOP_STOP && in.eop)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (key_evt[2]) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign unused_key3 = key_evt[3];

    // Outputs.
    always_comb begin
        rd_word = mem_q[rd_ptr_q];
        rd_vld  = vld_q[rd_ptr_q];

        LEDG    = '0;
        LEDG[0] = (state_q == S_ARMED);
        LEDG[1] = (state_q == S_CAPTURE);
        LEDG[2] = (state_q == S_DONE);
        if (rd_vld) begin
            LEDG[6:3] = rd_word[DW+3:DW];
        end
        LEDG[7] = sat_q;

        for (int unsigned i = 0; i < NDIG; i++) begin
            hex_disp[i] = rd_vld ? seg7(rd_word[4*i +: 4]) : 7'h7F;
        end
    end

endmodule
